// File: rtl/fpgc_mem_pkg.sv
// Shared constants and helpers for the parameterised data memory.
package fpgc_mem_pkg;

    // Legal read-pipeline depths.
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 2;

    // Widest word the lane-merge helper handles; callers cast to their width.
    localparam int MAX_DATA_W = 256;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    // Replace the bytes of word selected by be with the matching bytes of data.
    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] word,
        input logic [MAX_DATA_W-1:0] data,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] res;
        res = word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_bank.sv
// Storage array with byte-lane masked write and combinational read port.
module data_mem_bank
    import fpgc_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_idx,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [DATA_W-1:0]   i_data,
    output logic [DATA_W-1:0]   o_rd_word
);

    // Contents start at zero at configuration and are never touched by reset.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    assign o_rd_word = r_mem[i_idx];

    // Lane-masked write; only enabled bytes of the addressed word change.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_idx] <= DATA_W'(lane_merge(MAX_DATA_W'(r_mem[i_idx]),
                                               MAX_DATA_W'(i_data),
                                               MAX_BE_W'(i_be)));
        end
    end

endmodule

// File: rtl/data_mem_param.sv
// Parameterised data memory: range check, write forwarding into the read
// result, and a 1- or 2-stage read pipeline with clear/hold control.
module data_mem_param
    import fpgc_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   data,
    input  logic                re,
    input  logic                clear,
    input  logic                hold,
    output logic [DATA_W-1:0]   q,
    output logic                q_valid,
    output logic                addr_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;

    if (DATA_W % 8 != 0) begin : g_chk_dw
        $error("data_mem_param: DATA_W must be a multiple of 8");
    end
    if (DATA_W > MAX_DATA_W) begin : g_chk_dw_max
        $error("data_mem_param: DATA_W exceeds MAX_DATA_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("data_mem_param: DEPTH must be a power of 2 (>= 2)");
    end
    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_chk_lat
        $error("data_mem_param: LATENCY must be 1 or 2");
    end

    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_bank_we;
    logic [DATA_W-1:0] w_rd_word;
    logic [BE_W-1:0]   w_fwd_be;
    logic [DATA_W-1:0] w_data_p0;
    logic              w_vld_p0;
    logic              w_err_p0;

    logic [DATA_W-1:0] r_data_p1;
    logic              r_vld_p1;
    logic              r_err_p1;

    function automatic logic [DATA_W-1:0] fwd_merge(
        input logic [DATA_W-1:0] word,
        input logic [DATA_W-1:0] wdata,
        input logic [BE_W-1:0]   lanes
    );
        return DATA_W'(lane_merge(MAX_DATA_W'(word), MAX_DATA_W'(wdata),
                                  MAX_BE_W'(lanes)));
    endfunction

    // In range iff every address bit above the index field is zero.
    if (ADDR_W > IDX_W) begin : g_rng_wide
        assign w_in_range = (addr[ADDR_W-1:IDX_W] == '0);
        assign w_idx      = addr[IDX_W-1:0];
    end else begin : g_rng_narrow
        assign w_in_range = 1'b1;
        assign w_idx      = IDX_W'(addr);
    end

    // Writes go straight to storage regardless of hold, clear or reset.
    assign w_bank_we = we & w_in_range;

    data_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk       (clk),
        .i_we      (w_bank_we),
        .i_idx     (w_idx),
        .i_be      (be),
        .i_data    (data),
        .o_rd_word (w_rd_word)
    );

    // ---- stage p0: read the array and forward same-cycle write bytes ----
    assign w_fwd_be = we ? be : '0;

    // Stage-1 result; out-of-range requests read as zero.
    always_comb begin
        w_data_p0 = '0;
        if (w_in_range) w_data_p0 = fwd_merge(w_rd_word, data, w_fwd_be);
    end

    assign w_vld_p0 = re | we;
    assign w_err_p0 = w_vld_p0 & ~w_in_range;

    // ---- stage p1: first output register (reset > clear > hold > advance) ----
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_data_p1 <= '0;
            r_vld_p1  <= 1'b0;
            r_err_p1  <= 1'b0;
        end else if (!hold) begin
            r_data_p1 <= w_data_p0;
            r_vld_p1  <= w_vld_p0;
            r_err_p1  <= w_err_p0;
        end
    end

    if (LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] r_data_p2;
        logic              r_vld_p2;
        logic              r_err_p2;

        // ---- stage p2: extra output register, same priority as p1 ----
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                r_data_p2 <= '0;
                r_vld_p2  <= 1'b0;
                r_err_p2  <= 1'b0;
            end else if (!hold) begin
                r_data_p2 <= r_data_p1;
                r_vld_p2  <= r_vld_p1;
                r_err_p2  <= r_err_p1;
            end
        end

        assign q        = r_data_p2;
        assign q_valid  = r_vld_p2;
        assign addr_err = r_err_p2;
    end else begin : g_lat1
        assign q        = r_data_p1;
        assign q_valid  = r_vld_p1;
        assign addr_err = r_err_p1;
    end

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench: one LATENCY=1 and one LATENCY=2 instance share stimulus;
// a reference memory model produces expected results that a monitor checks.
module tb_data_mem_param;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, we, re, clear, hold;
    logic [31:0] addr, data;
    logic [3:0]  be;

    logic [31:0] oq [2];
    logic        ov [2];
    logic        oe [2];

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [128];
    ent_t        qa [$];
    ent_t        qb [$];

    always #5 clk = ~clk;

    data_mem_param #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .be(be), .data(data),
        .re(re), .clear(clear), .hold(hold),
        .q(oq[0]), .q_valid(ov[0]), .addr_err(oe[0])
    );

    data_mem_param #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .be(be), .data(data),
        .re(re), .clear(clear), .hold(hold),
        .q(oq[1]), .q_valid(ov[1]), .addr_err(oe[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s lat%0d @%0t actual=%h required=%h", name, k + 1, $time, act, exp);
        end
    endtask

    // One request cycle: apply inputs, run the reference model, then clock.
    task automatic cyc(input logic r, input logic c, input logic h, input logic w,
                       input logic rd, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d);
        ent_t        e;
        logic [31:0] mask;
        logic        inr;
        reset = r; clear = c; hold = h; we = w; re = rd; addr = a; be = b; data = d;
        inr  = (a < 32'd128);
        mask = 32'd0;
        if (w) mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        e.vld  = w | rd;
        e.err  = (w | rd) & ~inr;
        e.data = inr ? ((mem[a[6:0]] & ~mask) | (d & mask)) : 32'd0;
        if (w && inr) mem[a[6:0]] = e.data;
        if (!(r || c || h)) begin
            qa.push_back(e);
            qb.push_back(e);
        end
        @(posedge clk);
        #3;
    endtask

    // Monitor: checks every edge's outputs against the scoreboard.
    initial begin : monitor
        logic        s_r, s_c, s_h;
        logic [31:0] pq [2];
        logic        pv [2];
        logic        pe [2];
        ent_t        e;
        forever begin
            @(posedge clk);
            s_r = reset; s_c = clear; s_h = hold;
            #1;
            if (s_r || s_c) begin
                qa.delete();
                qb.delete();
                qb.push_back('0);
            end
            for (int k = 0; k < 2; k++) begin
                if (s_r || s_c) begin
                    chk(s_r ? "reset_q" : "clear_q", k, oq[k], 32'd0);
                    chk(s_r ? "reset_valid" : "clear_valid", k, 32'(ov[k]), 32'd0);
                    chk(s_r ? "reset_err" : "clear_err", k, 32'(oe[k]), 32'd0);
                end else if (s_h) begin
                    chk("hold_q", k, oq[k], pq[k]);
                    chk("hold_valid", k, 32'(ov[k]), 32'(pv[k]));
                    chk("hold_err", k, 32'(oe[k]), 32'(pe[k]));
                end else if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
                    chk("scoreboard_empty", k, 32'(ov[k]), 32'hFFFF_FFFF);
                end else begin
                    if (k == 0) e = qa.pop_front();
                    else        e = qb.pop_front();
                    chk("valid", k, 32'(ov[k]), 32'(e.vld));
                    chk("addr_err", k, 32'(oe[k]), 32'(e.err));
                    if (e.vld) chk("q", k, oq[k], e.data);
                end
                pq[k] = oq[k]; pv[k] = ov[k]; pe[k] = oe[k];
            end
        end
    end

    initial begin : stim
        logic [31:0] a;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        reset = 1'b1; clear = 1'b0; hold = 1'b0; we = 1'b0; re = 1'b0;
        addr = 32'd0; be = 4'd0; data = 32'd0;

        // reset, then reads of never-written words
        cyc(1, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        cyc(1, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'd7, 4'h0, 32'd0);
        // full write then read back, partial write with forwarding, read back
        cyc(0, 0, 0, 1, 0, 32'd5, 4'hF, 32'hDEADBEEF);
        cyc(0, 0, 0, 0, 1, 32'd5, 4'h0, 32'd0);
        cyc(0, 0, 0, 1, 0, 32'd5, 4'h5, 32'h11223344);
        cyc(0, 0, 0, 0, 1, 32'd5, 4'h0, 32'd0);
        // be=0 write returns the unmodified word
        cyc(0, 0, 0, 1, 0, 32'd5, 4'h0, 32'hFFFFFFFF);
        // out-of-range write must not alias onto index 72
        cyc(0, 0, 0, 1, 0, 32'd72, 4'hF, 32'hCAFEF00D);
        cyc(0, 0, 0, 1, 0, 32'd200, 4'hF, 32'h12345678);
        cyc(0, 0, 0, 0, 1, 32'd72, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'h8000_0048, 4'h0, 32'd0);
        // read then write same address next cycle
        cyc(0, 0, 0, 0, 1, 32'd72, 4'h0, 32'd0);
        cyc(0, 0, 0, 1, 0, 32'd72, 4'hF, 32'h0BADC0DE);
        // back-to-back reads 1,2,3 with a one-cycle hold on the second
        cyc(0, 0, 0, 1, 0, 32'd1, 4'hF, 32'h00000101);
        cyc(0, 0, 0, 1, 0, 32'd2, 4'hF, 32'h00000202);
        cyc(0, 0, 0, 1, 0, 32'd3, 4'hF, 32'h00000303);
        cyc(0, 0, 0, 0, 1, 32'd1, 4'h0, 32'd0);
        cyc(0, 0, 1, 1, 1, 32'd2, 4'h2, 32'h0000AA00);
        cyc(0, 0, 0, 0, 1, 32'd2, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'd3, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        // clear with hold while two reads are in flight; the write persists
        cyc(0, 0, 0, 0, 1, 32'd1, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'd2, 4'h0, 32'd0);
        cyc(0, 1, 1, 1, 1, 32'd9, 4'hF, 32'h99999999);
        cyc(0, 0, 0, 0, 1, 32'd9, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        // reset mid-read, write during reset, then re-read
        cyc(0, 0, 0, 0, 1, 32'd5, 4'h0, 32'd0);
        cyc(1, 0, 0, 1, 1, 32'd10, 4'hF, 32'hA5A5A5A5);
        cyc(0, 0, 0, 0, 1, 32'd5, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'd10, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 1, 32'd72, 4'h0, 32'd0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 7))
                0:       a = $urandom | 32'h0000_0080;
                1, 2:    a = $urandom_range(0, 255);
                default: a = $urandom_range(0, 15);
            endcase
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
        end

        cyc(0, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        cyc(0, 0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_param.md
DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 128, meaning number of words; it must be a power of 2.
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning input address width.
REQ-004 The block SHALL have parameter LATENCY, default 1, meaning read pipeline depth; legal values are 1 or 2.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all logic uses the rising edge.
REQ-006 The block SHALL have port reset, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port addr, input, width ADDR_W: word address.
REQ-008 The block SHALL have port we, input, width 1: write request.
REQ-009 The block SHALL have port be, input, width DATA_W/8: byte-lane write enables; bit i covers data[8i+7:8i].
REQ-010 The block SHALL have port data, input, width DATA_W: write data.
REQ-011 The block SHALL have port re, input, width 1: read request.
REQ-012 The block SHALL have port clear, input, width 1: pipeline flush.
REQ-013 The block SHALL have port hold, input, width 1: pipeline stall.
REQ-014 The block SHALL have port q, output, width DATA_W: read data.
REQ-015 The block SHALL have port q_valid, output, width 1: q holds the result of a read request.
REQ-016 The block SHALL have port addr_err, output, width 1: the request currently at the output stage was out of range.

Function
REQ-017 A request (we or re) SHALL be in range iff addr < DEPTH; the index SHALL be addr[log2(DEPTH)-1:0].
REQ-018 A write SHALL update only lanes with be=1, on the clock edge where we=1 and the request is in range, independent of hold and clear.
REQ-019 An out-of-range write SHALL leave memory unchanged.
REQ-020 For every request, the read-stage-1 result SHALL be the memory word at the index, with lanes where we&be=1 replaced by data (byte-merged write forwarding) and no extra cycle of delay.
REQ-021 The read-stage-1 result SHALL be all-zero and addr_err SHALL be 1 for an out-of-range request.
REQ-022 Stage-1 valid SHALL equal re|we.
REQ-023 With LATENCY=1, q, q_valid and addr_err SHALL be registered once, so the result appears on the cycle after the request.
REQ-024 With LATENCY=2, one additional register stage SHALL follow, giving results 2 cycles after the request.
REQ-025 Pipeline stage update priority SHALL be reset > clear > hold > advance.
REQ-026 Clear SHALL zero data, valid and err in all stages in the same edge.
REQ-027 Hold SHALL freeze all stages, including their data, valid and err.
REQ-028 A request issued while hold=1 SHALL NOT be captured for reading; its write SHALL still occur.
REQ-029 Simultaneous clear and hold SHALL act as clear.
REQ-030 A write issued one cycle after a read of the same address SHALL NOT alter the already-captured read result.
REQ-031 be=0 with we=1 SHALL write nothing and SHALL return the unmodified word.

Reset
REQ-032 On reset, q SHALL be 0, q_valid SHALL be 0, addr_err SHALL be 0, and all pipeline stages SHALL be 0.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 Memory SHALL be initialised to 0 at configuration.
REQ-035 A write with reset=1 SHALL be performed.
REQ-036 Reset asserted mid-pipeline SHALL discard in-flight reads.

Structure
REQ-037 Shared package fpgc_mem_pkg SHALL hold the LATENCY legal-value constants and a function for byte-lane merging (word, data, be).
REQ-038 Sub-module data_mem_bank SHALL contain the storage array and lane-masked write, with a combinational read port; data_mem_param SHALL hold the forwarding, range check and pipeline.
REQ-039 The block SHALL use elaboration-time checks on DATA_W%8, power-of-2 DEPTH and LATENCY∈{1,2}.

Verification
REQ-040 Directed test, defaults: write 0xDEADBEEF to addr 5 with be=1111 -> next cycle q=0xDEADBEEF, q_valid=1; then read 5 -> q=0xDEADBEEF.
REQ-041 Directed test: word at 5 is 0xDEADBEEF; write 0x11223344 with be=0101 -> forwarded q=0xDE22BE44; a later read returns the same.
REQ-042 Directed test: write to addr 200 (DEPTH 128) -> memory at index 72 unchanged, q=0, addr_err=1; reading 72 returns prior data.
REQ-043 Directed test, LATENCY=2: reads of 1,2,3 back-to-back, hold on the 2nd cycle for 1 cycle -> results in order, each valid once, stalled output stable during hold.
REQ-044 Directed test: clear together with hold while two reads are in flight -> q=0 and q_valid=0 next cycle; writes issued during the clear persist.
REQ-045 Directed test: reset mid-read -> outputs 0 next cycle; prior memory contents intact on re-read.
